// File: rtl/clock_div_pkg.sv
// ---------------------------------------------------------------------------
// clock_div_pkg
// Shared defaults for the synchronous decade prescaler, plus a helper that
// returns the period of a stage's TICK strobe in enabled master-clock cycles.
// ---------------------------------------------------------------------------
package clock_div_pkg;

  localparam int DEFAULT_DIV    = 10;
  localparam int DEFAULT_STAGES = 7;

  // Enabled master cycles between two TICK pulses of stage k.
  function automatic int stage_period(input int k, input int div);
    return div ** (k + 1);
  endfunction

endpackage : clock_div_pkg

// File: rtl/prescaler_stage.sv
// ---------------------------------------------------------------------------
// prescaler_stage
// One divide-by-DIV stage of the synchronous prescaler cascade. The counter
// advances only on cycles where EN_IN is high, so every stage runs off the
// master clock and no derived clock is ever used as a clock.
//
// Ports:
//   CLOCK    in   master clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   SYNC_CLR in   synchronous clear of counter and outputs (beats EN_IN)
//   EN_IN    in   single-cycle advance enable from the previous stage
//   CARRY    out  combinational: EN_IN high while the counter sits at DIV-1
//   TICK     out  registered CARRY, one cycle wide
//   CLK_OUT  out  registered square wave, high while count >= (DIV+1)/2
// ---------------------------------------------------------------------------
module prescaler_stage
  import clock_div_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic SYNC_CLR,
  input  logic EN_IN,
  output logic CARRY,
  output logic TICK,
  output logic CLK_OUT
);

  localparam int                 CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DIV - 1);
  // Low for (DIV+1)/2 counts, high for the remaining DIV/2 counts.
  localparam logic [CNT_W-1:0]   HIGH_FROM = CNT_W'((DIV + 1) / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;
  logic             clk_q;

  assign CARRY = EN_IN && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (EN_IN) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: every state flop gets an explicit reset value and is written with
  // non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else if (SYNC_CLR) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= CARRY;
      // Sampled from the pre-edge count, so CLK_OUT lags the count by a cycle
      // and simply holds while the stage is not enabled.
      clk_q  <= (cnt_q >= HIGH_FROM);
    end
  end

  assign TICK    = tick_q;
  assign CLK_OUT = clk_q;

endmodule : prescaler_stage

// File: rtl/decade_prescaler.sv
// ---------------------------------------------------------------------------
// decade_prescaler
// Fully synchronous cascade of NUM_STAGES divide-by-DIV stages on a single
// master clock. Stage k advances on the carry of stage k-1, so TICK[k] is a
// one-cycle clock-enable every DIV^(k+1) enabled cycles and CLK_OUT[k] a
// near-50% square wave with the same period.
//
// Ports:
//   CLOCK     in   master clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   ENABLE    in   count enable for stage 0; low freezes the whole chain
//   SYNC_CLR  in   synchronous clear of all stages, priority over ENABLE
//   TICK      out  [NUM_STAGES] per-stage one-cycle strobes
//   CLK_OUT   out  [NUM_STAGES] per-stage square waves
// Optional (macro DECADE_PRESCALER_RATE_SEL_EN):
//   RATE_SEL  in   [$clog2(NUM_STAGES)] stage selector
//   TICK_SEL  out  TICK[RATE_SEL] delayed one cycle, 0 if out of range
//   CLK_SEL   out  CLK_OUT[RATE_SEL] delayed one cycle, 0 if out of range
// ---------------------------------------------------------------------------
module decade_prescaler
  import clock_div_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_STAGES,
  parameter int DIV        = DEFAULT_DIV
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  SYNC_CLR,
  output logic [NUM_STAGES-1:0] TICK,
  output logic [NUM_STAGES-1:0] CLK_OUT
`ifdef DECADE_PRESCALER_RATE_SEL_EN
  ,
  input  logic [$clog2(NUM_STAGES)-1:0] RATE_SEL,
  output logic                          TICK_SEL,
  output logic                          CLK_SEL
`endif
);

  logic [NUM_STAGES-1:0] en_w;
  logic [NUM_STAGES-1:0] carry_w;
  logic [NUM_STAGES-1:0] tick_w;
  logic [NUM_STAGES-1:0] clk_w;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign en_w[k] = ENABLE;
    end else begin : g_next
      assign en_w[k] = carry_w[k-1];
    end

    prescaler_stage #(
      .DIV (DIV)
    ) u_stage (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .SYNC_CLR(SYNC_CLR),
      .EN_IN   (en_w[k]),
      .CARRY   (carry_w[k]),
      .TICK    (tick_w[k]),
      .CLK_OUT (clk_w[k])
    );
  end

  // The last stage's carry has no consumer.
  logic unused_last_carry;
  assign unused_last_carry = carry_w[NUM_STAGES-1];

  assign TICK    = tick_w;
  assign CLK_OUT = clk_w;

`ifdef DECADE_PRESCALER_RATE_SEL_EN
  logic sel_ok;
  logic tick_sel_d, tick_sel_q;
  logic clk_sel_d,  clk_sel_q;

  always_comb begin
    sel_ok     = (32'(RATE_SEL) < NUM_STAGES);
    tick_sel_d = 1'b0;
    clk_sel_d  = 1'b0;
    if (sel_ok) begin
      tick_sel_d = tick_w[RATE_SEL];
      clk_sel_d  = clk_w[RATE_SEL];
    end
  end

  // Plain registered copies; a RATE_SEL change may cut a pulse or level short.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_sel_q <= 1'b0;
      clk_sel_q  <= 1'b0;
    end else begin
      tick_sel_q <= tick_sel_d;
      clk_sel_q  <= clk_sel_d;
    end
  end

  assign TICK_SEL = tick_sel_q;
  assign CLK_SEL  = clk_sel_q;
`else
  // Rate selector not built: only the raw TICK/CLK_OUT vectors are exported.
`endif

endmodule : decade_prescaler
